// File: rtl/ov7670_reg_sequencer.sv
// OV7670 bring-up sequencer: walks a register table in a synchronous ROM and issues
// one SCCB write per entry, with retries, inter-write gaps and a soft-reset settle delay.
`timescale 1ns/1ps

module ov7670_reg_sequencer #(
    parameter int unsigned NUM_REGS       = 76,
    parameter logic [7:0]  SLAVE_ADDR     = 8'h42,
    parameter int unsigned GAP_CYC        = 1000,
    parameter int unsigned RESET_WAIT_CYC = 1_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_req,
    output logic [7:0]  sccb_dev,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ack,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  reg_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_REQ,
        S_GAP,
        S_RST_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [19:0] GAP_LAST  = 20'(GAP_CYC);
    localparam logic [19:0] RST_LAST  = 20'(RESET_WAIT_CYC);
    localparam logic [7:0]  IDX_END   = 8'(NUM_REGS);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    state_t      state;
    logic [19:0] wait_cnt;
    logic [19:0] wait_last;
    logic [7:0]  retry_cnt;
    logic        soft_reset;

    // Writing COM7 with bit 7 set resets the sensor, which needs a long settle time.
    assign soft_reset = (sccb_reg == 8'h12) && sccb_val[7];
    assign wait_last  = (state == S_RST_WAIT) ? RST_LAST : GAP_LAST;

    // NOTE: every state and output register is assigned with <= in one clocked block,
    // so all of them update together on the edge and no ordering races exist.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            retry_cnt <= '0;
            rom_addr  <= '0;
            sccb_req  <= 1'b0;
            sccb_dev  <= '0;
            sccb_reg  <= '0;
            sccb_val  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            reg_index <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state     <= S_FETCH;
                        reg_index <= '0;
                        retry_cnt <= '0;
                        rom_addr  <= '0;
                        done      <= 1'b0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    if (rom_data == 16'hFFFF) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        sccb_dev <= SLAVE_ADDR;
                        sccb_reg <= rom_data[15:8];
                        sccb_val <= rom_data[7:0];
                        sccb_req <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    // nack is tested first so a simultaneous ack/nack is a retry
                    if (sccb_nack) begin
                        sccb_req <= 1'b0;
                        if (retry_cnt == RETRY_MAX) begin
                            state <= S_ERR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            retry_cnt <= retry_cnt + 8'd1;
                            wait_cnt  <= '0;
                            state     <= S_GAP;
                        end
                    end else if (sccb_ack) begin
                        sccb_req  <= 1'b0;
                        retry_cnt <= '0;
                        reg_index <= reg_index + 8'd1;
                        wait_cnt  <= '0;
                        state     <= soft_reset ? S_RST_WAIT : S_GAP;
                    end
                end
                S_GAP, S_RST_WAIT: begin
                    if (wait_cnt == wait_last) begin
                        if (reg_index == IDX_END) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_FETCH;
                            rom_addr <= reg_index;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 20'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// Self-checking bench for ov7670_reg_sequencer: a timestamp-based behavioural model is
// compared against the DUT every cycle, plus directed literal checks and random scenarios.
`timescale 1ns/1ps

module tb_ov7670_reg_sequencer;

    localparam int NUM_REGS = 8;
    localparam int GAP      = 4;
    localparam int RWAIT    = 50;
    localparam int MAXR     = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic        sccb_req;
    logic [7:0]  sccb_dev, sccb_reg, sccb_val;
    logic        sccb_ack = 1'b0;
    logic        sccb_nack = 1'b0;
    logic        busy, done, error;
    logic [7:0]  reg_index;

    ov7670_reg_sequencer #(
        .NUM_REGS(NUM_REGS), .SLAVE_ADDR(8'h42), .GAP_CYC(GAP),
        .RESET_WAIT_CYC(RWAIT), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .reset(rst_n), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_req(sccb_req), .sccb_dev(sccb_dev), .sccb_reg(sccb_reg), .sccb_val(sccb_val),
        .sccb_ack(sccb_ack), .sccb_nack(sccb_nack), .busy(busy), .done(done),
        .error(error), .reg_index(reg_index)
    );

    always #5 clk = ~clk;

    logic [15:0] rom_tbl [256];
    always @(posedge clk) rom_data <= rom_tbl[rom_addr];

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ---------------- behavioural model (event timestamps) ----------------
    typedef enum {M_IDLE, M_WAIT, M_REQ, M_DONE, M_ERR} mode_t;
    mode_t      m_mode = M_IDLE;
    int         m_pend = 0;
    int         m_retry = 0;
    logic       m_busy = 0, m_done = 0, m_error = 0, m_req = 0;
    logic [7:0] m_idx = 0, m_rom_addr = 0, m_dev = 0, m_reg = 0, m_val = 0;

    task automatic reset_model();
        m_mode = M_IDLE; m_retry = 0; m_pend = 0;
        m_busy = 0; m_done = 0; m_error = 0; m_req = 0;
        m_idx = 0; m_rom_addr = 0; m_dev = 0; m_reg = 0; m_val = 0;
    endtask

    task automatic model_step();
        logic [15:0] ent;
        case (m_mode)
            M_IDLE, M_DONE, M_ERR: if (start) begin
                m_busy = 1; m_done = 0; m_error = 0; m_idx = 0; m_retry = 0;
                m_rom_addr = 0; m_pend = edge_cnt + 2; m_mode = M_WAIT;
            end
            M_WAIT: begin
                // the wait expires two edges before the next request would rise
                if (edge_cnt == m_pend - 2) begin
                    if (int'(m_idx) == NUM_REGS) begin
                        m_mode = M_DONE; m_done = 1; m_busy = 0;
                    end else begin
                        m_rom_addr = m_idx;
                    end
                end else if (edge_cnt == m_pend) begin
                    ent = rom_tbl[m_idx];
                    if (ent == 16'hFFFF) begin
                        m_mode = M_DONE; m_done = 1; m_busy = 0;
                    end else begin
                        m_req = 1; m_dev = 8'h42; m_reg = ent[15:8]; m_val = ent[7:0];
                        m_mode = M_REQ;
                    end
                end
            end
            M_REQ: begin
                if (sccb_nack) begin
                    m_req = 0;
                    if (m_retry == MAXR) begin
                        m_mode = M_ERR; m_error = 1; m_busy = 0;
                    end else begin
                        m_retry++; m_pend = edge_cnt + GAP + 3; m_mode = M_WAIT;
                    end
                end else if (sccb_ack) begin
                    m_req = 0; m_retry = 0;
                    m_pend = edge_cnt + ((m_reg == 8'h12 && m_val[7]) ? RWAIT : GAP) + 3;
                    m_idx = m_idx + 8'd1;
                    m_mode = M_WAIT;
                end
            end
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) reset_model();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("error", error, m_error);
        check("sccb_req", sccb_req, m_req);
        check("reg_index", reg_index, m_idx);
        check("rom_addr", rom_addr, m_rom_addr);
        check("sccb_dev", sccb_dev, m_dev);
        check("sccb_reg", sccb_reg, m_reg);
        check("sccb_val", sccb_val, m_val);
    end

    // ---------------- SCCB responder and request monitor ----------------
    int  nack_budget [256];
    bit  both_first  [256];
    int  nacks_given [256];
    int  lat_min = 0, lat_max = 0;
    bit  stray_en = 0;
    int  lat_left = -1;
    int  ri;
    int  ack_q[$];
    int  rise_q[$];
    logic [23:0] rise_f[$];
    logic [7:0]  rise_i[$];
    logic prev_req = 1'b0;

    initial forever begin
        @(negedge clk);
        sccb_ack = 0; sccb_nack = 0;
        if (rst_n && sccb_req === 1'b1) begin
            if (lat_left < 0) lat_left = $urandom_range(lat_max, lat_min);
            if (lat_left == 0) begin
                ri = int'(reg_index);
                if (nacks_given[ri] < nack_budget[ri]) begin
                    if (both_first[ri] && nacks_given[ri] == 0) sccb_ack = 1;
                    sccb_nack = 1;
                    nacks_given[ri]++;
                end else begin
                    sccb_ack = 1;
                    ack_q.push_back(edge_cnt + 1);
                end
                lat_left = -1;
            end else begin
                lat_left--;
            end
        end else begin
            lat_left = -1;
            if (rst_n && stray_en && $urandom_range(5, 0) == 0) sccb_ack = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (sccb_req === 1'b1 && !prev_req) begin
            rise_q.push_back(edge_cnt);
            rise_f.push_back({sccb_dev, sccb_reg, sccb_val});
            rise_i.push_back(reg_index);
        end
        prev_req = (sccb_req === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_scenario();
        for (int i = 0; i < 256; i++) begin
            nack_budget[i] = 0; both_first[i] = 0; nacks_given[i] = 0;
        end
        ack_q.delete(); rise_q.delete(); rise_f.delete(); rise_i.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); #2 start = 1;
        @(negedge clk); #2 start = 0;
    endtask

    task automatic wait_finish(input int budget, input bit spam);
        int n = 0;
        bit fin = 0;
        while (!fin && n < budget) begin
            @(negedge clk);
            n++;
            if (!busy && (done || error)) fin = 1;
            else #2 start = spam && ($urandom_range(15, 0) == 0);
        end
        #2 start = 0;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL finish_timeout: no done/error within %0d cycles", budget);
        end
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        while (sccb_req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sccb_req !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: sccb_req not seen within %0d cycles", budget);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int L, exp_rises, fail_idx, nrise;
        bit exp_err;
        logic [15:0] v;

        for (int i = 0; i < 256; i++) rom_tbl[i] = 16'hFFFF;
        clear_scenario();
        #1 rst_n = 0;
        reset_model();
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_req", sccb_req, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_rom_addr", rom_addr, 8'h00);

        // three-entry table with soft reset first, immediate acks
        rom_tbl[0] = 16'h1280; rom_tbl[1] = 16'h1204; rom_tbl[2] = 16'h40D0; rom_tbl[3] = 16'hFFFF;
        pulse_start();
        wait_finish(500, 0);
        check("t1_req_count", rise_q.size(), 3);
        if (rise_q.size() >= 3 && ack_q.size() >= 2) begin
            check("t1_fields0", rise_f[0], 24'h421280);
            check("t1_fields1", rise_f[1], 24'h421204);
            check("t1_fields2", rise_f[2], 24'h4240D0);
            check("t1_gap_after_softreset", rise_q[1] - ack_q[0], 53);
            check("t1_gap_normal", rise_q[2] - ack_q[1], 7);
        end
        check("t1_done", done, 1'b1);
        check("t1_busy", busy, 1'b0);

        // restart from DONE, with a start pulse landing while in REQ
        clear_scenario();
        lat_min = 3; lat_max = 3;
        pulse_start();
        check("restart_done_clear", done, 1'b0);
        check("restart_rom_addr", rom_addr, 8'h00);
        check("restart_busy", busy, 1'b1);
        wait_req(20);
        #2 start = 1;
        @(negedge clk); #2 start = 0;
        wait_finish(500, 0);
        check("start_in_req_count", rise_q.size(), 3);
        check("start_in_req_done", done, 1'b1);

        // entry 0 NACKs twice, then acks
        clear_scenario();
        lat_min = 0; lat_max = 2;
        rom_tbl[0] = 16'h3A04; rom_tbl[1] = 16'h4010; rom_tbl[2] = 16'hFFFF;
        nack_budget[0] = 2;
        pulse_start();
        wait_finish(500, 0);
        check("retry_req_count", rise_q.size(), 4);
        if (rise_q.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("retry_fields", rise_f[i], 24'h423A04);
                check("retry_index", rise_i[i], 8'h00);
            end
        end
        check("retry_done", done, 1'b1);

        // simultaneous ack+nack is a retry; stray acks while idle/gapping are ignored
        clear_scenario();
        stray_en = 1;
        rom_tbl[0] = 16'h1100; rom_tbl[1] = 16'h6B4A; rom_tbl[2] = 16'hFFFF;
        nack_budget[1] = 1; both_first[1] = 1;
        pulse_start();
        wait_finish(500, 0);
        check("both_req_count", rise_q.size(), 3);
        check("both_done", done, 1'b1);
        stray_en = 0;

        // entry 1 NACKs four times -> error
        clear_scenario();
        rom_tbl[0] = 16'h0C00; rom_tbl[1] = 16'h3E19; rom_tbl[2] = 16'h7033; rom_tbl[3] = 16'hFFFF;
        nack_budget[1] = 4;
        pulse_start();
        wait_finish(500, 0);
        check("err_error", error, 1'b1);
        check("err_done", done, 1'b0);
        check("err_reg_index", reg_index, 8'h01);
        check("err_busy", busy, 1'b0);
        check("err_req", sccb_req, 1'b0);
        check("err_req_count", rise_q.size(), 5);
        repeat (30) @(negedge clk);
        check("err_no_more_reqs", rise_q.size(), 5);

        // asynchronous reset while a request is outstanding
        clear_scenario();
        lat_min = 3; lat_max = 3;
        pulse_start();
        wait_req(20);
        #2 rst_n = 0;
        reset_model();
        #1;
        check("async_reset_req", sccb_req, 1'b0);
        check("async_reset_busy", busy, 1'b0);
        check("async_reset_error", error, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        nrise = rise_q.size();
        repeat (12) @(negedge clk);
        check("post_reset_idle", busy, 1'b0);
        check("post_reset_no_req", rise_q.size(), nrise);

        // full table without terminator ends at NUM_REGS
        clear_scenario();
        lat_min = 0; lat_max = 1;
        for (int i = 0; i < NUM_REGS; i++) rom_tbl[i] = 16'h2000 + 16'(i);
        rom_tbl[NUM_REGS] = 16'h5555;
        pulse_start();
        wait_finish(1000, 0);
        check("full_req_count", rise_q.size(), NUM_REGS);
        check("full_reg_index", reg_index, 8'(NUM_REGS));
        check("full_done", done, 1'b1);

        // randomized scenarios
        for (int it = 0; it < 30; it++) begin
            clear_scenario();
            L = $urandom_range(NUM_REGS, 1);
            lat_min = 0; lat_max = $urandom_range(3, 0);
            stray_en = ($urandom_range(3, 0) == 0);
            for (int i = 0; i < 256; i++) rom_tbl[i] = 16'hFFFF;
            for (int i = 0; i < L; i++) begin
                v = 16'($urandom);
                if (v == 16'hFFFF) v = 16'hFFFE;
                rom_tbl[i] = v;
                if ($urandom_range(19, 0) == 0) nack_budget[i] = 4;
                else if ($urandom_range(5, 0) == 0) nack_budget[i] = $urandom_range(3, 1);
                if (nack_budget[i] > 0) both_first[i] = ($urandom_range(1, 0) == 1);
            end
            exp_rises = 0; exp_err = 0; fail_idx = 0;
            for (int i = 0; i < L && !exp_err; i++) begin
                if (nack_budget[i] > MAXR) begin
                    exp_rises += MAXR + 1; exp_err = 1; fail_idx = i;
                end else begin
                    exp_rises += nack_budget[i] + 1;
                end
            end
            pulse_start();
            wait_finish(3000, 1);
            check("rnd_req_count", rise_q.size(), exp_rises);
            check("rnd_error", error, exp_err);
            check("rnd_done", done, !exp_err);
            check("rnd_reg_index", reg_index, exp_err ? 8'(fail_idx) : 8'(L));
        end
        stray_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
